// File: rtl/noc_pkg.sv
// Shared definitions for the bidirectional ring NoC: port/direction encoding,
// destination field position and the shortest-path route computation.
package noc_pkg;

  typedef enum logic [1:0] {
    DIR_HOST  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  localparam int NUM_PORTS = 3;

  function automatic int dest_msb(input int packet_size);
    return packet_size - 1;
  endfunction

  function automatic int dest_lsb(input int packet_size, input int router_bits);
    return packet_size - router_bits;
  endfunction

  // Ties (rd == n/2) go right, which also makes a 2-router ring always route right.
  function automatic dir_t route_dir(input int unsigned k, input int unsigned d,
                                     input int unsigned n);
    int unsigned rd;
    rd = (d + n - k) % n;
    if (d == k) begin
      return DIR_HOST;
    end else if (rd <= n / 32'd2) begin
      return DIR_RIGHT;
    end else begin
      return DIR_LEFT;
    end
  endfunction

endpackage

// File: rtl/ring_router_hs.sv
// One ring router: host/left/right input FIFOs, per-output round-robin arbiters,
// registered link outputs gated by the neighbour's conservative full flag.
module ring_router_hs
  import noc_pkg::*;
#(
  parameter int PACKET_SIZE = 8,
  parameter int NUM_ROUTERS = 4,
  parameter int ROUTER_BITS = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROUTER_ID   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] host_data_in,
  input  logic                   host_valid_in,
  output logic                   host_ready_out,
  output logic [PACKET_SIZE-1:0] host_data_out,
  output logic                   host_valid_out,
  output logic                   host_err,
  input  logic [PACKET_SIZE-1:0] from_left_data,
  input  logic                   from_left_valid,
  output logic                   from_left_full,
  input  logic [PACKET_SIZE-1:0] from_right_data,
  input  logic                   from_right_valid,
  output logic                   from_right_full,
  output logic [PACKET_SIZE-1:0] to_left_data,
  output logic                   to_left_valid,
  input  logic                   to_left_full,
  output logic [PACKET_SIZE-1:0] to_right_data,
  output logic                   to_right_valid,
  input  logic                   to_right_full
);

  localparam int MSB = dest_msb(PACKET_SIZE);
  localparam int LSB = dest_lsb(PACKET_SIZE, ROUTER_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);

  logic [PACKET_SIZE-1:0] mem_r [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr_r [NUM_PORTS];
  logic [AW-1:0]          wr_ptr_r [NUM_PORTS];
  logic [CW-1:0]          count_r [NUM_PORTS];
  logic [1:0]             rr_ptr_r [NUM_PORTS];
  logic [NUM_PORTS-1:0]   push_s, pop_s, head_valid_s, out_ok_s;
  logic [PACKET_SIZE-1:0] push_data_s [NUM_PORTS];
  logic [PACKET_SIZE-1:0] head_data_s [NUM_PORTS];
  logic [PACKET_SIZE-1:0] win_data_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]   grant_s [NUM_PORTS];
  dir_t                   head_dir_s [NUM_PORTS];
  logic                   in_bad_s, accept_s;

  assign in_bad_s       = 32'(host_data_in[MSB:LSB]) >= NUM_ROUTERS;
  assign host_ready_out = !rst && (count_r[0] != CW'(FIFO_DEPTH));
  assign accept_s       = host_valid_in && host_ready_out;
  assign push_s         = {from_right_valid, from_left_valid, accept_s && !in_bad_s};
  assign push_data_s[0] = host_data_in;
  assign push_data_s[1] = from_left_data;
  assign push_data_s[2] = from_right_data;

  // A pop in the same cycle is deliberately not credited, so the flag is conservative.
  assign from_left_full  = (32'(count_r[1]) + 32'(from_left_valid)) >= FIFO_DEPTH;
  assign from_right_full = (32'(count_r[2]) + 32'(from_right_valid)) >= FIFO_DEPTH;

  // FIFO heads and their routing decision.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_valid_s[i] = count_r[i] != '0;
      head_data_s[i]  = mem_r[i][rd_ptr_r[i]];
      head_dir_s[i]   = route_dir(ROUTER_ID, 32'(head_data_s[i][MSB:LSB]), NUM_ROUTERS);
    end
  end

  // Round-robin grant per output, starting the search at that output's pointer.
  always_comb begin
    int idx;
    idx      = 0;
    out_ok_s = {!to_right_full, !to_left_full, 1'b1};
    pop_s    = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      grant_s[o]    = '0;
      win_data_s[o] = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
        idx = (32'(rr_ptr_r[o]) + off) % NUM_PORTS;
        if (grant_s[o] == '0 && out_ok_s[o] && head_valid_s[idx] &&
            head_dir_s[idx] == dir_t'(2'(o))) begin
          grant_s[o][idx] = 1'b1;
          win_data_s[o]   = head_data_s[idx];
        end else begin
          grant_s[o] = grant_s[o];
        end
      end
      pop_s = pop_s | grant_s[o];
    end
  end

  // FIFO storage; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push_s[i]) mem_r[i][wr_ptr_r[i]] <= push_data_s[i];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_ptr_r[i] <= '0;
        wr_ptr_r[i] <= '0;
        count_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= (wr_ptr_r[i] == LAST) ? '0 : wr_ptr_r[i] + AW'(1);
        if (pop_s[i])  rd_ptr_r[i] <= (rd_ptr_r[i] == LAST) ? '0 : rd_ptr_r[i] + AW'(1);
        count_r[i] <= count_r[i] + CW'(push_s[i]) - CW'(pop_s[i]);
      end
    end
  end

  // Arbiter pointers plus registered link and host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) rr_ptr_r[o] <= 2'd0;
      host_valid_out <= 1'b0;
      host_data_out  <= '0;
      host_err       <= 1'b0;
      to_left_valid  <= 1'b0;
      to_left_data   <= '0;
      to_right_valid <= 1'b0;
      to_right_data  <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant_s[o][i]) rr_ptr_r[o] <= (i == NUM_PORTS - 1) ? 2'd0 : 2'(i + 1);
        end
      end
      host_valid_out <= |grant_s[DIR_HOST];
      to_left_valid  <= |grant_s[DIR_LEFT];
      to_right_valid <= |grant_s[DIR_RIGHT];
      if (|grant_s[DIR_HOST])  host_data_out <= win_data_s[DIR_HOST];
      if (|grant_s[DIR_LEFT])  to_left_data  <= win_data_s[DIR_LEFT];
      if (|grant_s[DIR_RIGHT]) to_right_data <= win_data_s[DIR_RIGHT];
      host_err <= accept_s && in_bad_s;
    end
  end

endmodule

// File: rtl/noc_ring_hs.sv
// Ring fabric top: NUM_ROUTERS identical routers wired to their modulo neighbours,
// with host buses flattened one PACKET_SIZE slice per router.
module noc_ring_hs
  import noc_pkg::*;
#(
  parameter int PACKET_SIZE = 8,
  parameter int NUM_ROUTERS = 4,
  parameter int ROUTER_BITS = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PACKET_SIZE*NUM_ROUTERS-1:0] host_data_in,
  input  logic [NUM_ROUTERS-1:0]             host_valid_in,
  output logic [NUM_ROUTERS-1:0]             host_ready_out,
  output logic [PACKET_SIZE*NUM_ROUTERS-1:0] host_data_out,
  output logic [NUM_ROUTERS-1:0]             host_valid_out,
  output logic [NUM_ROUTERS-1:0]             host_err
);

  logic [PACKET_SIZE-1:0] to_left_data_s  [NUM_ROUTERS];
  logic [PACKET_SIZE-1:0] to_right_data_s [NUM_ROUTERS];
  logic [NUM_ROUTERS-1:0] to_left_valid_s, to_right_valid_s;
  logic [NUM_ROUTERS-1:0] left_full_s, right_full_s;

  for (genvar i = 0; i < NUM_ROUTERS; i++) begin : g_router
    localparam int L = (i + NUM_ROUTERS - 1) % NUM_ROUTERS;
    localparam int R = (i + 1) % NUM_ROUTERS;

    ring_router_hs #(
      .PACKET_SIZE(PACKET_SIZE),
      .NUM_ROUTERS(NUM_ROUTERS),
      .ROUTER_BITS(ROUTER_BITS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ROUTER_ID  (i)
    ) u_router (
      .clk             (clk),
      .rst             (rst),
      .host_data_in    (host_data_in[i*PACKET_SIZE +: PACKET_SIZE]),
      .host_valid_in   (host_valid_in[i]),
      .host_ready_out  (host_ready_out[i]),
      .host_data_out   (host_data_out[i*PACKET_SIZE +: PACKET_SIZE]),
      .host_valid_out  (host_valid_out[i]),
      .host_err        (host_err[i]),
      .from_left_data  (to_right_data_s[L]),
      .from_left_valid (to_right_valid_s[L]),
      .from_left_full  (left_full_s[i]),
      .from_right_data (to_left_data_s[R]),
      .from_right_valid(to_left_valid_s[R]),
      .from_right_full (right_full_s[i]),
      .to_left_data    (to_left_data_s[i]),
      .to_left_valid   (to_left_valid_s[i]),
      .to_left_full    (right_full_s[L]),
      .to_right_data   (to_right_data_s[i]),
      .to_right_valid  (to_right_valid_s[i]),
      .to_right_full   (left_full_s[R])
    );
  end

endmodule
